resample_scheduler: RTL and testbench
=====================================

// Module: resample_scheduler
// PURPOSE
//   Sequencer/arbiter sharing one polyphase resampling MAC datapath (rate L/M) between two
//   audio channels. Per channel it tracks the polyphase index and the need for a new input
//   sample, runs the req/ack handshakes with the two sources and two sinks, and issues
//   shift/start strobes to the datapath. Sits between the channel I/O and the filter core.
// PARAMETERS
//   L      160  interpolation factor; number of polyphase branches
//   L_LOG  8    width of phase index; L <= 2**L_LOG
//   M      147  decimation factor; 1 <= M <= L
// PORTS
//   clk       in   1      single clock, rising edge
//   rst       in   1      asynchronous, active-low reset (0 = reset)
//   chan_en   in   2      per-channel enable, sampled only in IDLE
//   req_in    out  2      per-channel input request to source
//   ack_in    in   2      per-channel input acknowledge; data valid while ack high
//   req_out   out  2      per-channel output request to sink
//   ack_out   in   2      per-channel output acknowledge
//   dp_chan   out  1      channel whose delay line and data muxes the datapath uses
//   dp_phase  out  L_LOG  polyphase branch index for current computation
//   dp_shift  out  1      datapath shifts data_in into dp_chan delay line on this edge
//   dp_start  out  1      one-cycle pulse: begin MAC for dp_chan at dp_phase
//   dp_valid  in   1      datapath result ready, held until next dp_start
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; req_in, req_out, dp_start = 0; dp_chan, dp_phase = 0;
//     phase[0..1] = 0; need_in[0..1] = 1; round-robin pointer so ch0 is served first.
//   State registers and all outputs except dp_shift are registered.
//   dp_shift = req_in[dp_chan] & ack_in[dp_chan] (combinational).
//   IDLE: pick the next enabled channel after the last served one (round robin); none
//     enabled -> stay. Latch ch into dp_chan, phase[ch] into dp_phase.
//     need_in[ch] -> FETCH, else -> START.
//   FETCH: req_in[ch]=1 until the edge where ack_in[ch]=1; at that edge dp_shift fires,
//     need_in[ch] <= 0, req_in drops next cycle, -> START.
//   START: dp_start=1 for exactly one cycle -> WAIT.
//   WAIT: hold until dp_valid=1 -> OUTPUT. No timeout. dp_valid ignored in other states.
//   OUTPUT: req_out[ch]=1 until ack_out[ch]=1. On that edge: req_out drops next cycle;
//     phase[ch] < L-M -> phase[ch] += M, need_in unchanged (0);
//     else -> phase[ch] -= (L-M), need_in[ch] <= 1; last <= ch; -> IDLE.
//   Phase arithmetic in L_LOG bits; result always in [0, L-1]; M = L gives one input/output.
//   Ack on a channel whose req is low, or on the non-selected channel: ignored, no effect.
//   At most one req_in/req_out bit high at any time; never req_in and req_out together.
//   chan_en falling mid-transaction: transaction completes; channel skipped next IDLE.
//   Phase and need_in of a disabled channel are preserved; resumes where it left off.
//   Minimum latency per output, no input: IDLE->START->WAIT (+datapath)->OUTPUT = 3 cycles
//     + datapath latency + 1 ack cycle. Stalls on ack are unbounded.
// TESTING
//   1 Reset: hold rst=0 with clk running -> all req/dp_start 0; release, chan_en=01 ->
//     req_in[0] high 2nd cycle after release; dp_phase=0.
//   2 Single ch0, sink/source ack 1 cycle after req, dp_valid 3 cycles after dp_start:
//     dp_phase sequence 0,147,134,121,...; 160 outputs consume exactly 1+147 inputs; phase
//     returns to 0 after output 160.
//   3 chan_en=11: outputs alternate ch0,ch1,ch0,...; each channel's phase sequence matches
//     scenario 2 independently; dp_chan matches the active req bit.
//   4 Backpressure: ack_out[0] held low 50 cycles -> req_out[0] stays high, no dp_start,
//     no req_in, phase unchanged; ack then -> phase advances by exactly one step.
//   5 Async reset mid-WAIT (rst falls between clock edges) -> outputs 0 immediately, no
//     clock needed; after release ch0 restarts at phase 0 with input fetch.
//   6 chan_en=10, spurious ack_in[0]/ack_out[0] pulses -> only ch1 served, ch0 state
//     untouched, no dp_shift from ch0 acks.

Source files
------------

// File: rtl/resample_scheduler.sv
// Sequencer/arbiter that time-shares one polyphase L/M resampling MAC between two
// audio channels: round-robin channel pick, input fetch, MAC start, result delivery.
module resample_scheduler #(
    parameter int L     = 160,
    parameter int L_LOG = 8,
    parameter int M     = 147
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       chan_en_i,
    output logic [1:0]       req_in_o,
    input  logic [1:0]       ack_in_i,
    output logic [1:0]       req_out_o,
    input  logic [1:0]       ack_out_i,
    output logic             dp_chan_o,
    output logic [L_LOG-1:0] dp_phase_o,
    output logic             dp_shift_o,
    output logic             dp_start_o,
    input  logic             dp_valid_i
);

    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, OUTPUT} state_e;

    localparam logic [L_LOG-1:0] STEP_FWD  = L_LOG'(M);
    localparam logic [L_LOG-1:0] STEP_BACK = L_LOG'(L - M);

    state_e                  state_q;
    logic [1:0][L_LOG-1:0]   phase_q;
    logic [1:0]              need_q;
    logic                    last_q;
    logic                    chan_q;
    logic [L_LOG-1:0]        dp_phase_q;
    logic [1:0]              req_in_q;
    logic [1:0]              req_out_q;
    logic                    dp_start_q;

    logic                    pick_vld_d;
    logic                    pick_ch_d;
    logic                    wrap_d;
    logic [L_LOG-1:0]        phase_nxt_d;

    // Round robin: the channel after the last served one wins, else the same one again.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_ch_d  = 1'b0;
        if (chan_en_i[~last_q]) begin
            pick_vld_d = 1'b1;
            pick_ch_d  = ~last_q;
        end else if (chan_en_i[last_q]) begin
            pick_vld_d = 1'b1;
            pick_ch_d  = last_q;
        end
    end

    // Advancing by M wraps past L exactly when phase >= L-M; a wrap consumes one input.
    assign wrap_d      = (phase_q[chan_q] >= STEP_BACK);
    assign phase_nxt_d = wrap_d ? (phase_q[chan_q] - STEP_BACK) : (phase_q[chan_q] + STEP_FWD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            need_q     <= 2'b11;
            last_q     <= 1'b1;
            chan_q     <= 1'b0;
            dp_phase_q <= '0;
            req_in_q   <= '0;
            req_out_q  <= '0;
            dp_start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        chan_q     <= pick_ch_d;
                        dp_phase_q <= phase_q[pick_ch_d];
                        if (need_q[pick_ch_d]) begin
                            req_in_q[pick_ch_d] <= 1'b1;
                            state_q             <= FETCH;
                        end else begin
                            dp_start_q <= 1'b1;
                            state_q    <= START;
                        end
                    end
                end
                FETCH: begin
                    if (ack_in_i[chan_q]) begin
                        req_in_q       <= '0;
                        need_q[chan_q] <= 1'b0;
                        dp_start_q     <= 1'b1;
                        state_q        <= START;
                    end
                end
                START: begin
                    dp_start_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (dp_valid_i) begin
                        req_out_q[chan_q] <= 1'b1;
                        state_q           <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (ack_out_i[chan_q]) begin
                        req_out_q       <= '0;
                        phase_q[chan_q] <= phase_nxt_d;
                        if (wrap_d) need_q[chan_q] <= 1'b1;
                        last_q          <= chan_q;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_in_o   = req_in_q;
    assign req_out_o  = req_out_q;
    assign dp_chan_o  = chan_q;
    assign dp_phase_o = dp_phase_q;
    assign dp_start_o = dp_start_q;
    assign dp_shift_o = req_in_q[chan_q] & ack_in_i[chan_q];

endmodule

// File: tb/tb_resample_scheduler.sv
// Bench for resample_scheduler: transaction-level channel model checked every cycle,
// randomized source/sink/datapath responders, plus literal pins on the phase sequence.
module tb_resample_scheduler;

    localparam int L = 160;
    localparam int L_LOG = 8;
    localparam int M = 147;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       chan_en, req_in, ack_in, req_out, ack_out;
    logic             dp_chan, dp_shift, dp_start, dp_valid;
    logic [L_LOG-1:0] dp_phase;

    always #5 clk = ~clk;

    resample_scheduler #(.L(L), .L_LOG(L_LOG), .M(M)) dut (
        .clk_i(clk), .rst_ni(rst_n), .chan_en_i(chan_en),
        .req_in_o(req_in), .ack_in_i(ack_in), .req_out_o(req_out), .ack_out_i(ack_out),
        .dp_chan_o(dp_chan), .dp_phase_o(dp_phase), .dp_shift_o(dp_shift),
        .dp_start_o(dp_start), .dp_valid_i(dp_valid)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rr(input logic [1:0] en, input int last);
        if (en[1-last]) return 1 - last;
        if (en[last]) return last;
        return -1;
    endfunction

    // ---------------- behavioural model (transaction level) ----------------
    int   m_phase[2];
    bit   m_need[2];
    int   m_last, m_ch, m_stage, prev_c = -1;
    bit   m_busy;
    int   starts[2] = '{0, 0};
    int   fetches[2] = '{0, 0};
    int   outs[2] = '{0, 0};
    int   alt_bad = 0, sh0 = 0;
    int   log0[$], log1[$];
    bit   snap_v = 0;
    int   snap_fetch, snap_need, snap_phase;
    logic [1:0] e_req_in, e_req_out;
    logic e_start, e_chan;
    int   e_phase;
    logic neg_shift = 1'b0, neg_chan = 1'b0;

    always @(negedge clk) begin
        neg_shift = dp_shift;
        neg_chan  = dp_chan;
    end

    always begin : compare
        logic [1:0] s_en, s_ai, s_ao;
        logic s_dv, s_sh;
        int c, nx;
        @(posedge clk);
        s_en = chan_en; s_ai = ack_in; s_ao = ack_out; s_dv = dp_valid; s_sh = neg_shift;
        if (!rst_n) begin
            m_phase = '{0, 0}; m_need = '{1, 1}; m_last = 1; m_busy = 0; m_stage = 0; m_ch = 0;
            e_req_in = '0; e_req_out = '0; e_start = 1'b0; e_chan = 1'b0; e_phase = 0;
        end else begin
            chk("dp_shift", int'(s_sh), int'(m_busy && m_stage == 0 && s_ai[m_ch]));
            if (s_sh && !neg_chan) sh0++;
            if (!m_busy) begin
                c = rr(s_en, m_last);
                if (c >= 0) begin
                    if (s_en == 2'b11 && prev_c == c) alt_bad++;
                    prev_c = c;
                    if (c == 0 && starts[0] == 160 && !snap_v) begin
                        snap_v = 1; snap_fetch = fetches[0];
                        snap_need = int'(m_need[0]); snap_phase = m_phase[0];
                    end
                    if (c == 0 && log0.size() < 4) log0.push_back(m_phase[0]);
                    if (c == 1 && log1.size() < 4) log1.push_back(m_phase[1]);
                    starts[c]++;
                    m_busy = 1; m_ch = c; e_chan = c[0]; e_phase = m_phase[c];
                    if (m_need[c]) begin m_stage = 0; e_req_in[c] = 1'b1; end
                    else begin m_stage = 1; e_start = 1'b1; end
                end
            end else begin
                case (m_stage)
                    0: if (s_ai[m_ch]) begin
                        m_need[m_ch] = 0; fetches[m_ch]++;
                        e_req_in = '0; e_start = 1'b1; m_stage = 1;
                    end
                    1: begin e_start = 1'b0; m_stage = 2; end
                    2: if (s_dv) begin e_req_out[m_ch] = 1'b1; m_stage = 3; end
                    default: if (s_ao[m_ch]) begin
                        e_req_out = '0;
                        nx = m_phase[m_ch] + M;
                        if (nx >= L) m_need[m_ch] = 1;
                        m_phase[m_ch] = nx % L;
                        m_last = m_ch; m_busy = 0; outs[m_ch]++;
                    end
                endcase
            end
        end
        #1;
        chk("req_in", int'(req_in), int'(e_req_in));
        chk("req_out", int'(req_out), int'(e_req_out));
        chk("dp_start", int'(dp_start), int'(e_start));
        chk("dp_chan", int'(dp_chan), int'(e_chan));
        chk("dp_phase", int'(dp_phase), e_phase);
    end

    // ---------------- source / sink / datapath responders ----------------
    bit spur = 0, hold_out0 = 0, rand_dly = 0;
    int dly_in[2], dly_out[2];
    int cin[2] = '{0, 0};
    int cout[2] = '{0, 0};
    int dcnt = 0;

    always begin : driver
        @(posedge clk); #2;
        if (!rst_n) begin
            ack_in = '0; ack_out = '0; dp_valid = 1'b0; dcnt = 0;
            cin = '{0, 0}; cout = '{0, 0};
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (req_in[ch]) begin
                    if (cin[ch] == 0) dly_in[ch] = rand_dly ? int'($urandom_range(0, 3)) : 0;
                    ack_in[ch] = (cin[ch] >= dly_in[ch]);
                    cin[ch]++;
                end else begin
                    cin[ch] = 0;
                    ack_in[ch] = spur && ch == 0 && ($urandom_range(0, 2) == 0);
                end
                if (req_out[ch]) begin
                    if (cout[ch] == 0) dly_out[ch] = rand_dly ? int'($urandom_range(0, 3)) : 0;
                    ack_out[ch] = (cout[ch] >= dly_out[ch]) && !(hold_out0 && ch == 0);
                    cout[ch]++;
                end else begin
                    cout[ch] = 0;
                    ack_out[ch] = spur && ch == 0 && ($urandom_range(0, 2) == 0);
                end
            end
            if (dp_start) begin
                dp_valid = 1'b0;
                dcnt = rand_dly ? int'($urandom_range(1, 5)) : 3;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) dp_valid = 1'b1;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic wait_starts(input int ch, input int n, input int budget, input string name);
        int k = 0;
        while (starts[ch] < n && k < budget) begin cyc(); k++; end
        chk(name, int'(starts[ch] >= n), 1);
    endtask

    initial begin : main
        int s0, s1, b0, b1, p, hi, bad, k, ph0, sh_b;
        rst_n = 1'b0; chan_en = '0; ack_in = '0; ack_out = '0; dp_valid = 1'b0;
        repeat (4) cyc();
        chk("rst req_in", int'(req_in), 0);
        chk("rst req_out", int'(req_out), 0);
        chk("rst dp_start", int'(dp_start), 0);
        chk("rst dp_phase", int'(dp_phase), 0);
        rst_n = 1'b1; chan_en = 2'b01;
        cyc();
        chk("first req_in", int'(req_in), 1);
        chk("first phase", int'(dp_phase), 0);

        // single channel, one full phase cycle
        wait_starts(0, 161, 5000, "s2 161 outputs");
        chk("s2 log0[0]", log0[0], 0);
        chk("s2 log0[1]", log0[1], 147);
        chk("s2 log0[2]", log0[2], 134);
        chk("s2 log0[3]", log0[3], 121);
        chk("s2 phase wraps to 0", snap_phase, 0);
        chk("s2 fetches in 160 outputs", snap_fetch, 147);
        chk("s2 inputs incl next", snap_fetch + snap_need, 148);
        chk("s2 dut phase", int'(dp_phase), 0);

        // both channels, random handshake delays
        chan_en = 2'b11; rand_dly = 1; b0 = starts[0]; b1 = starts[1];
        wait_starts(1, b1 + 40, 3000, "s3 ch1 outputs");
        chk("s3 ch1 log[0]", log1[0], 0);
        chk("s3 ch1 log[1]", log1[1], 147);
        chk("s3 alternation", alt_bad, 0);
        s0 = starts[0] - b0; s1 = starts[1] - b1;
        chk("s3 balance", int'(s0 - s1 <= 1 && s1 - s0 <= 1), 1);
        for (int i = 0; i < 10; i++) begin
            chan_en = 2'($urandom_range(0, 3));
            repeat (25) cyc();
        end

        // sink backpressure on ch0
        chan_en = 2'b01; rand_dly = 0; hold_out0 = 1;
        k = 0;
        while (!req_out[0] && k < 500) begin cyc(); k++; end
        chk("s4 req_out wait", int'(req_out[0]), 1);
        p = dp_phase; hi = 0; bad = 0;
        repeat (50) begin
            cyc();
            if (req_out[0]) hi++;
            if (dp_start || req_in != 2'b00) bad++;
        end
        chk("s4 req_out held", hi, 50);
        chk("s4 no activity", bad, 0);
        chk("s4 phase held", int'(dp_phase), p);
        hold_out0 = 0; s0 = starts[0];
        wait_starts(0, s0 + 1, 200, "s4 resume");
        chk("s4 one step", int'(dp_phase), (p + M) % L);

        // async reset in the middle of WAIT
        k = 0;
        while (!dp_start && k < 200) begin cyc(); k++; end
        chk("s5 dp_start wait", int'(dp_start), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("s5 async req_in", int'(req_in), 0);
        chk("s5 async req_out", int'(req_out), 0);
        chk("s5 async dp_start", int'(dp_start), 0);
        chk("s5 async dp_phase", int'(dp_phase), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("s5 restart fetch", int'(req_in), 1);
        chk("s5 restart phase", int'(dp_phase), 0);

        // ch0 disabled, spurious ch0 acks
        chan_en = 2'b10; spur = 1;
        repeat (30) cyc();
        ph0 = m_phase[0]; s0 = starts[0]; s1 = starts[1]; sh_b = sh0;
        chk("s6 ch0 finished at 147", ph0, 147);
        repeat (300) cyc();
        chk("s6 no ch0 starts", starts[0] - s0, 0);
        chk("s6 ch1 served", int'(starts[1] - s1 > 10), 1);
        chk("s6 no ch0 shift", sh0 - sh_b, 0);
        chan_en = 2'b01; spur = 0; s0 = starts[0];
        wait_starts(0, s0 + 1, 200, "s6 ch0 resume");
        chk("s6 ch0 phase kept", int'(dp_phase), 147);
        chk("s6 ch0 no refetch", int'(req_in), 0);

        repeat (20) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
